// File: rtl/pht_update_writer_pkg.sv
// rtl/pht_update_writer_pkg.sv - PHT write-side types, sizes and helper functions
package pht_update_writer_pkg;

  localparam int PC_WIDTH                        = 32;
  localparam int INSN_ADDR_BIT_WIDTH             = 2;
  localparam int PHT_ENTRY_NUM_BIT_WIDTH         = 10;
  localparam int PHT_ENTRY_WIDTH                 = 2;
  localparam int BRANCH_GLOBAL_HISTORY_BIT_WIDTH = 8;
  localparam int PHT_BANK_NUM_BIT_WIDTH          = 2;
  localparam int PHT_QUEUE_SIZE                  = 32;
  localparam int PHT_QUEUE_SIZE_BIT_WIDTH        = $clog2(PHT_QUEUE_SIZE);

  typedef logic [PC_WIDTH-1:0]                        PC_Path;
  typedef logic [BRANCH_GLOBAL_HISTORY_BIT_WIDTH-1:0] BranchGlobalHistoryPath;
  typedef logic [PHT_ENTRY_NUM_BIT_WIDTH-1:0]         PHT_IndexPath;
  typedef logic [PHT_ENTRY_WIDTH-1:0]                 PHT_EntryPath;
  typedef logic [PHT_QUEUE_SIZE_BIT_WIDTH-1:0]        PhtQueuePointerPath;

  localparam PHT_EntryPath PHT_ENTRY_MAX = '1;

  typedef struct packed {
    logic                   valid;
    logic                   isCondBr;
    PC_Path                 brAddr;
    BranchGlobalHistoryPath globalHistory;
    PHT_EntryPath           phtPrevValue;
    logic                   execTaken;
  } BranchResult;

  typedef struct packed {
    PHT_IndexPath idx;
    PHT_EntryPath value;
  } PhtWriteEntry;

  // Banks are interleaved on the low index bits
  function automatic logic IsBankConflict(PHT_IndexPath a, PHT_IndexPath b);
    return a[PHT_BANK_NUM_BIT_WIDTH-1:0] == b[PHT_BANK_NUM_BIT_WIDTH-1:0];
  endfunction

  // gshare index: word address bits XOR history (history zero-extended/truncated by the cast)
  function automatic PHT_IndexPath ToPHT_Index(PC_Path addr, BranchGlobalHistoryPath hist);
    PHT_IndexPath histIdx;
    histIdx = PHT_IndexPath'(hist);
    return addr[INSN_ADDR_BIT_WIDTH +: PHT_ENTRY_NUM_BIT_WIDTH] ^ histIdx;
  endfunction

  // 2-bit saturating counter step
  function automatic PHT_EntryPath UpdatePHT_Counter(PHT_EntryPath prev, logic taken);
    PHT_EntryPath next;
    if (taken) next = (prev == PHT_ENTRY_MAX) ? prev : prev + PHT_EntryPath'(1);
    else       next = (prev == '0)            ? prev : prev - PHT_EntryPath'(1);
    return next;
  endfunction

endpackage

// File: rtl/pht_update_writer_fifo.sv
// rtl/pht_update_writer_fifo.sv - count-tracked circular FIFO of PhtWriteEntry (module pht_write_fifo)
module pht_write_fifo
  import pht_update_writer_pkg::*;
#(
  parameter int DEPTH = PHT_QUEUE_SIZE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  PhtWriteEntry           pushData,
  input  logic                   pop,
  output PhtWriteEntry           headData,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  PhtWriteEntry     mem [DEPTH];
  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;
  logic             doPush;
  logic             doPop;

  // A push into a full FIFO is only accepted when a pop frees a slot the same cycle
  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign doPop    = pop & ~empty;
  assign doPush   = push & (~full | doPop);
  assign headData = mem[headPtr];

  // Storage array; contents are meaningless while count says empty
  always_ff @(posedge clk) begin
    if (doPush) mem[tailPtr] <= pushData;
  end

  // Pointers wrap naturally; full/empty come from count alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (doPush) tailPtr <= tailPtr + 1'b1;
      if (doPop)  headPtr <= headPtr + 1'b1;
      if (doPush & ~doPop)      count <= count + 1'b1;
      else if (doPop & ~doPush) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pht_update_writer.sv
// rtl/pht_update_writer.sv - gshare PHT write side (optional same-cycle bypass: RSD_PHT_UPDATE_BYPASS_EN)
module pht_update_writer
  import pht_update_writer_pkg::*;
#(
  parameter int QUEUE_SIZE     = PHT_QUEUE_SIZE,  // power of 2
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  BranchResult                 brResult,
  input  logic                        rdValid,
  input  PHT_IndexPath                rdIdx,
  output logic                        phtWE,
  output PHT_IndexPath                phtWIdx,
  output PHT_EntryPath                phtWValue,
  output logic [$clog2(QUEUE_SIZE):0] queueCount,
  output logic                        queueFull,
  output logic [DROP_CNT_WIDTH-1:0]   dropCount
);

  logic         upd;
  PhtWriteEntry incoming;
  PhtWriteEntry head;
  logic         qEmpty;
  logic         canWrite;
  logic         bypass;
  logic         push;
  logic         drop;

  assign upd            = brResult.valid & brResult.isCondBr;
  assign incoming.idx   = ToPHT_Index(brResult.brAddr, brResult.globalHistory);
  assign incoming.value = UpdatePHT_Counter(brResult.phtPrevValue, brResult.execTaken);

  // Head drains unless the fetch side is reading the same bank this cycle
  assign canWrite = ~qEmpty & ~(rdValid & IsBankConflict(head.idx, rdIdx));

`ifdef RSD_PHT_UPDATE_BYPASS_EN
  // Only from an empty queue, so FIFO ordering is never violated
  assign bypass = rst_n & qEmpty & upd & ~(rdValid & IsBankConflict(incoming.idx, rdIdx));
`else
  assign bypass = 1'b0;
`endif

  assign push  = upd & ~bypass;
  assign drop  = upd & queueFull & ~canWrite;
  assign phtWE = canWrite | bypass;

  pht_write_fifo #(
    .DEPTH(QUEUE_SIZE)
  ) fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pushData(incoming),
    .pop     (canWrite),
    .headData(head),
    .count   (queueCount),
    .full    (queueFull),
    .empty   (qEmpty)
  );

  // Write-port data: bypassed update, else the head, else zero so reset/idle shows 0
  always_comb begin
    phtWIdx   = '0;
    phtWValue = '0;
    if (bypass) begin
      phtWIdx   = incoming.idx;
      phtWValue = incoming.value;
    end else if (!qEmpty) begin
      phtWIdx   = head.idx;
      phtWValue = head.value;
    end
  end

  // Saturating count of updates lost to a full queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     dropCount <= '0;
    else if (drop && ~&dropCount)   dropCount <= dropCount + 1'b1;
  end

endmodule

// File: tb/tb_pht_update_writer.sv
// tb/tb_pht_update_writer.sv - self-checking bench for pht_update_writer
module tb_pht_update_writer;
  import pht_update_writer_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  BranchResult  brResult;
  logic         rdValid;
  PHT_IndexPath rdIdx;
  logic         phtWE;
  PHT_IndexPath phtWIdx;
  PHT_EntryPath phtWValue;
  logic [5:0]   queueCount;
  logic         queueFull;
  logic [15:0]  dropCount;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pht_update_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .brResult  (brResult),
    .rdValid   (rdValid),
    .rdIdx     (rdIdx),
    .phtWE     (phtWE),
    .phtWIdx   (phtWIdx),
    .phtWValue (phtWValue),
    .queueCount(queueCount),
    .queueFull (queueFull),
    .dropCount (dropCount)
  );

  typedef struct {
    int idx;
    int value;
  } ModelEntry;

  ModelEntry modelQ[$];
  int        modelDrop = 0;

  function automatic int modelIndex(int unsigned addr, int unsigned hist);
    return int'(((addr >> 2) ^ hist) % 1024);
  endfunction

  function automatic int modelCounter(int prev, int taken);
    if (taken != 0) return (prev < 3) ? prev + 1 : 3;
    return (prev > 0) ? prev - 1 : 0;
  endfunction

  function automatic bit sameBank(int a, int b);
    return (a % 4) == (b % 4);
  endfunction

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending writes, checked every cycle
  always @(negedge clk) begin : compare
    bit upd, byp, deq;
    int newIdx, newVal;
    if (!rst_n) begin
      chk("rst_we", int'(phtWE), 0);
      chk("rst_idx", int'(phtWIdx), 0);
      chk("rst_val", int'(phtWValue), 0);
      chk("rst_count", int'(queueCount), 0);
      chk("rst_full", int'(queueFull), 0);
      chk("rst_drop", int'(dropCount), 0);
      modelQ.delete();
      modelDrop = 0;
    end else begin
      upd    = brResult.valid && brResult.isCondBr;
      newIdx = modelIndex(int'(brResult.brAddr), int'(brResult.globalHistory));
      newVal = modelCounter(int'(brResult.phtPrevValue), int'(brResult.execTaken));
      byp    = 1'b0;
`ifdef RSD_PHT_UPDATE_BYPASS_EN
      byp = upd && modelQ.size() == 0 && !(rdValid && sameBank(newIdx, int'(rdIdx)));
`endif
      deq = modelQ.size() != 0 && !(rdValid && sameBank(modelQ[0].idx, int'(rdIdx)));
      chk("m_we", int'(phtWE), (deq || byp) ? 1 : 0);
      if (deq) begin
        chk("m_idx", int'(phtWIdx), modelQ[0].idx);
        chk("m_val", int'(phtWValue), modelQ[0].value);
      end else if (byp) begin
        chk("m_byp_idx", int'(phtWIdx), newIdx);
        chk("m_byp_val", int'(phtWValue), newVal);
      end
      chk("m_count", int'(queueCount), modelQ.size());
      chk("m_full", int'(queueFull), (modelQ.size() == 32) ? 1 : 0);
      chk("m_drop", int'(dropCount), modelDrop);
      if (deq) void'(modelQ.pop_front());
      if (upd && !byp) begin
        if (modelQ.size() < 32) modelQ.push_back('{newIdx, newVal});
        else if (modelDrop < 65535) modelDrop++;
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setBr(bit v, bit cond, int unsigned addr, int hist, int prev, bit taken);
    brResult.valid         = v;
    brResult.isCondBr      = cond;
    brResult.brAddr        = PC_Path'(addr);
    brResult.globalHistory = BranchGlobalHistoryPath'(hist);
    brResult.phtPrevValue  = PHT_EntryPath'(prev);
    brResult.execTaken     = taken;
  endtask

  task automatic noBr();
    setBr(1'b0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    rst_n   = 1'b0;
    rdValid = 1'b0;
    rdIdx   = '0;
    noBr();
    repeat (3) nextCycle();
    #1;
    chk("reset_we", int'(phtWE), 0);
    chk("reset_count", int'(queueCount), 0);
    chk("reset_drop", int'(dropCount), 0);
    rst_n = 1'b1;
    nextCycle();

    // Basic: 0x100, hist 0, prev 1, taken -> idx 0x40, value 2
    setBr(1'b1, 1'b1, 32'h100, 0, 1, 1'b1);
    #1;
`ifdef RSD_PHT_UPDATE_BYPASS_EN
    chk("t1_byp_we", int'(phtWE), 1);
    chk("t1_byp_idx", int'(phtWIdx), 'h40);
    chk("t1_byp_val", int'(phtWValue), 2);
    nextCycle();
    noBr();
`else
    chk("t1_same_cycle_we", int'(phtWE), 0);
    nextCycle();
    noBr();
    #1;
    chk("t1_we", int'(phtWE), 1);
    chk("t1_idx", int'(phtWIdx), 'h40);
    chk("t1_val", int'(phtWValue), 2);
    chk("t1_count", int'(queueCount), 1);
`endif
    nextCycle();
    #1;
    chk("t1_count_after", int'(queueCount), 0);

    // Saturation and history XOR, back-to-back
    nextCycle();
    setBr(1'b1, 1'b1, 32'h200, 0, 3, 1'b1);        // idx 0x80, val 3
    nextCycle();
    setBr(1'b1, 1'b1, 32'h204, 'h05, 0, 1'b0);     // idx 0x81^0x05=0x84, val 0
`ifndef RSD_PHT_UPDATE_BYPASS_EN
    #1;
    chk("sat_a_idx", int'(phtWIdx), 'h80);
    chk("sat_a_val", int'(phtWValue), 3);
`endif
    nextCycle();
    setBr(1'b1, 1'b1, 32'h208, 0, 2, 1'b0);        // idx 0x82, val 1
`ifndef RSD_PHT_UPDATE_BYPASS_EN
    #1;
    chk("sat_b_idx", int'(phtWIdx), 'h84);
    chk("sat_b_val", int'(phtWValue), 0);
`endif
    nextCycle();
    noBr();
`ifndef RSD_PHT_UPDATE_BYPASS_EN
    #1;
    chk("sat_c_idx", int'(phtWIdx), 'h82);
    chk("sat_c_val", int'(phtWValue), 1);
`endif
    nextCycle();

    // Unconditional branch is ignored
    setBr(1'b1, 1'b0, 32'h300, 0, 1, 1'b1);
    nextCycle();
    noBr();
    #1;
    chk("uncond_we", int'(phtWE), 0);
    chk("uncond_count", int'(queueCount), 0);
    nextCycle();

    // Bank conflict: idx 4 vs read idx 8
    rdValid = 1'b1;
    rdIdx   = PHT_IndexPath'(8);
    setBr(1'b1, 1'b1, 32'h10, 0, 1, 1'b0);
    nextCycle();
    noBr();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("conf_we", int'(phtWE), 0);
      chk("conf_count", int'(queueCount), 1);
      nextCycle();
    end
    rdValid = 1'b0;
    #1;
    chk("conf_rel_we", int'(phtWE), 1);
    chk("conf_rel_idx", int'(phtWIdx), 4);
    nextCycle();

    // Full: 34 updates into a blocked queue
    rdValid = 1'b1;
    rdIdx   = '0;
    for (int k = 0; k < 34; k++) begin
      if (k == 32) chk("full_at_32", int'(queueFull), 1);
      setBr(1'b1, 1'b1, 32'(k * 16), 0, k % 4, k[0]);
      nextCycle();
    end
    noBr();
    #1;
    chk("full_count", int'(queueCount), 32);
    chk("full_flag", int'(queueFull), 1);
    chk("full_drop", int'(dropCount), 2);
    nextCycle();

    // Full with simultaneous dequeue; 0x1004 gives truncated idx 1
    rdIdx = PHT_IndexPath'(1);
    setBr(1'b1, 1'b1, 32'h1004, 0, 1, 1'b1);
    #1;
    chk("fdq_we", int'(phtWE), 1);
    chk("fdq_idx", int'(phtWIdx), 0);
    nextCycle();
    noBr();
    rdValid = 1'b0;
    #1;
    chk("fdq_count", int'(queueCount), 32);
    chk("fdq_drop", int'(dropCount), 2);
    chk("drain_first_idx", int'(phtWIdx), 4);
    chk("drain_first_val", int'(phtWValue), 2);
    repeat (32) nextCycle();
    #1;
    chk("drain_done", int'(queueCount), 0);

    // Async reset mid-drain with 5 pending
    rdValid = 1'b1;
    rdIdx   = '0;
    for (int k = 0; k < 5; k++) begin
      setBr(1'b1, 1'b1, 32'(k * 16 + 'h40), 0, 2, 1'b1);
      nextCycle();
    end
    noBr();
    rdValid = 1'b0;
    #1;
    chk("ar_pre_we", int'(phtWE), 1);
    chk("ar_pre_count", int'(queueCount), 5);
    rst_n = 1'b0;
    #1;
    chk("ar_we", int'(phtWE), 0);
    chk("ar_idx", int'(phtWIdx), 0);
    chk("ar_val", int'(phtWValue), 0);
    chk("ar_count", int'(queueCount), 0);
    chk("ar_drop", int'(dropCount), 0);
    repeat (2) nextCycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      #1;
      chk("ar_post_we", int'(phtWE), 0);
    end

    nextCycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
